regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/wb_queue.sv | 84 ++++++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback path.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // One-hot register mask for a destination address.
    function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] addr);
        logic [NREG-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Small FIFO of writeback requests. Besides head/empty/full it exports a
// mask of every register that one of its valid entries will write.
module wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_req_t         push_req,
    input  logic            pop,
    output wb_req_t         head,
    output logic            empty,
    output logic            full,
    output logic [NREG-1:0] match
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    wb_req_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap with an explicit compare.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= next_ptr(wr_ptr);
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= next_ptr(rd_ptr);
                vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Registers targeted by any entry still waiting in this queue.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) begin
                match = match | addr_onehot(mem[i].addr);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the in-order ALU writeback
// (req0) and the long-latency unit (req1). Each side is queued, a
// round-robin arbiter retires one write per cycle through a registered
// output stage, and a pending mask covers every write not yet committed.
module regfile_wb_arbiter #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int AW    = regfile_pkg::AW,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] pending,
    output logic            idle
);

    import regfile_pkg::*;

    wb_req_t         q0_in;
    wb_req_t         q1_in;
    wb_req_t         q0_head;
    wb_req_t         q1_head;
    logic            q0_empty;
    logic            q0_full;
    logic            q1_empty;
    logic            q1_full;
    logic [NREG-1:0] q0_match;
    logic [NREG-1:0] q1_match;
    logic [NREG-1:0] wb_oh;
    logic            push0;
    logic            push1;
    logic            gnt0;
    logic            gnt1;
    // 0: req0 was granted last, 1: req1 was granted last.
    logic            last_grant;

    // Ready depends on state only, so a full queue stays closed even while it pops.
    assign req0_ready = ~q0_full;
    assign req1_ready = ~q1_full;

    // Writes to x0 complete the handshake but never enter a queue.
    assign push0 = req0_valid & req0_ready & (req0_addr != '0);
    assign push1 = req1_valid & req1_ready & (req1_addr != '0);

    assign q0_in = '{addr: req0_addr, data: req0_data};
    assign q1_in = '{addr: req1_addr, data: req1_data};

    wb_queue #(.DEPTH(DEPTH)) u_q0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push0),
        .push_req (q0_in),
        .pop      (gnt0),
        .head     (q0_head),
        .empty    (q0_empty),
        .full     (q0_full),
        .match    (q0_match)
    );

    wb_queue #(.DEPTH(DEPTH)) u_q1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .push_req (q1_in),
        .pop      (gnt1),
        .head     (q1_head),
        .empty    (q1_empty),
        .full     (q1_full),
        .match    (q1_match)
    );

    // Round robin on the heads: on a tie the side not granted last wins.
    assign gnt0 = ~q0_empty & (q1_empty | last_grant);
    assign gnt1 = ~q1_empty & (q0_empty | ~last_grant);

    // Output stage: the granted head drives the register file next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            last_grant <= 1'b1;
        end else begin
            wb_we <= gnt0 | gnt1;
            if (gnt0) begin
                wb_addr    <= q0_head.addr;
                wb_data    <= q0_head.data;
                last_grant <= 1'b0;
            end else if (gnt1) begin
                wb_addr    <= q1_head.addr;
                wb_data    <= q1_head.data;
                last_grant <= 1'b1;
            end
        end
    end

    // A write stays pending until the edge that commits it to the register file.
    assign wb_oh   = wb_we ? addr_onehot(wb_addr) : '0;
    assign pending = q0_match | q1_match | wb_oh;
    assign idle    = q0_empty & q1_empty & ~wb_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases with literal expectations
// plus randomized traffic checked every cycle against a queue-level model.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0;
    logic            req0_ready;
    logic [AW-1:0]   req0_addr = '0;
    logic [XLEN-1:0] req0_data = '0;
    logic            req1_valid = 1'b0;
    logic            req1_ready;
    logic [AW-1:0]   req1_addr = '0;
    logic [XLEN-1:0] req1_data = '0;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] pending;
    logic            idle;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .pending    (pending),
        .idle       (idle)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file as seen by the rest of the core (x0 not special-cased here,
    // so any write to x0 would become visible).
    logic [XLEN-1:0] rf [NREG] = '{default: '0};
    always @(posedge clk) begin
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq0[$];
    ent_t            mq1[$];
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_data = '0;
    int              m_src = -1;
    int              m_last = 1;
    int              m_acc_cnt = 0;
    int              dut_wr_cnt = 0;
    bit              m_a0, m_a1;
    int              m_g;
    ent_t            m_e;

    function automatic bit pend_from(input int src, input logic [AW-1:0] a);
        bit hit = 0;
        if (src == 0) begin
            foreach (mq0[i]) if (mq0[i].addr == a) hit = 1;
        end else begin
            foreach (mq1[i]) if (mq1[i].addr == a) hit = 1;
        end
        if (m_we && m_src == src && m_addr == a) hit = 1;
        return hit;
    endfunction

    function automatic logic [NREG-1:0] m_pending();
        logic [NREG-1:0] p = '0;
        foreach (mq0[i]) p[mq0[i].addr] = 1'b1;
        foreach (mq1[i]) p[mq1[i].addr] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_src = -1; m_last = 1; m_acc_cnt = 0;
        end else begin
            m_a0 = req0_valid && (mq0.size() < DEPTH);
            m_a1 = req1_valid && (mq1.size() < DEPTH);
            if (m_a0 && req0_addr != '0 && pend_from(1, req0_addr)) begin
                miscompares++;
                $display("FAIL hazard: req0 wrote x%0d pending from req1", req0_addr);
            end
            if (m_a1 && req1_addr != '0 && pend_from(0, req1_addr)) begin
                miscompares++;
                $display("FAIL hazard: req1 wrote x%0d pending from req0", req1_addr);
            end
            m_g = -1;
            if (mq0.size() > 0 && mq1.size() > 0) m_g = (m_last == 1) ? 0 : 1;
            else if (mq0.size() > 0) m_g = 0;
            else if (mq1.size() > 0) m_g = 1;
            m_we = (m_g >= 0);
            if (m_g == 0) begin
                m_e = mq0.pop_front();
                m_addr = m_e.addr; m_data = m_e.data; m_src = 0; m_last = 0;
            end else if (m_g == 1) begin
                m_e = mq1.pop_front();
                m_addr = m_e.addr; m_data = m_e.data; m_src = 1; m_last = 1;
            end
            if (m_a0 && req0_addr != '0) begin
                mq0.push_back('{req0_addr, req0_data});
                m_acc_cnt++;
            end
            if (m_a1 && req1_addr != '0) begin
                mq1.push_back('{req1_addr, req1_data});
                m_acc_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("wb_we", 64'(wb_we), 64'(m_we));
        if (m_we) begin
            chk("wb_addr", 64'(wb_addr), 64'(m_addr));
            chk("wb_data", 64'(wb_data), 64'(m_data));
        end
        chk("req0_ready", 64'(req0_ready), 64'(mq0.size() < DEPTH));
        chk("req1_ready", 64'(req1_ready), 64'(mq1.size() < DEPTH));
        chk("pending", 64'(pending), 64'(m_pending()));
        chk("idle", 64'(idle), 64'(mq0.size() == 0 && mq1.size() == 0 && !m_we));
        if (!rst_n) dut_wr_cnt = 0;
        else if (wb_we) dut_wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int  a0n, a1n;
    bit  saw_nr0, saw_nr1, acc0, acc1, got;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single write from req0.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_pend_n1", 64'(pending[5]), 64'd1);
        chk("single_we_n1", 64'(wb_we), 64'd0);
        @(negedge clk);
        chk("single_we_n2", 64'(wb_we), 64'd1);
        chk("single_addr_n2", 64'(wb_addr), 64'd5);
        chk("single_data_n2", 64'(wb_data), 64'hDEADBEEF);
        chk("single_pend_n2", 64'(pending[5]), 64'd1);
        @(negedge clk);
        chk("single_we_n3", 64'(wb_we), 64'd0);
        chk("single_pend_n3", 64'(pending[5]), 64'd0);
        chk("single_rf5", 64'(rf[5]), 64'hDEADBEEF);

        // Asynchronous reset mid-cycle while a write is queued.
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h55;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_addr", 64'(wb_addr), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd1);
        chk("rst_ready1", 64'(req1_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Tie straight after reset: req0 goes first.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("tie_we_n2", 64'(wb_we), 64'd1);
        chk("tie_addr_n2", 64'(wb_addr), 64'd1);
        chk("tie_data_n2", 64'(wb_data), 64'h11);
        @(negedge clk);
        chk("tie_we_n3", 64'(wb_we), 64'd1);
        chk("tie_addr_n3", 64'(wb_addr), 64'd2);
        chk("tie_data_n3", 64'(wb_data), 64'h22);

        // Write to x0 is accepted and dropped.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("x0_ready", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("x0_we", 64'(wb_we), 64'd0);
            chk("x0_pending", 64'(pending), 64'd0);
        end
        chk("x0_rf0", 64'(rf[0]), 64'd0);

        // Saturation: both sides request every cycle.
        a0n = 1; a1n = 16; saw_nr0 = 0; saw_nr1 = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) begin
            req0_valid = 1'b1; req0_addr = AW'(a0n); req0_data = $urandom;
            req1_valid = 1'b1; req1_addr = AW'(a1n); req1_data = $urandom;
            @(negedge clk);
            acc0 = req0_ready; acc1 = req1_ready;
            if (!req0_ready) saw_nr0 = 1;
            if (!req1_ready) saw_nr1 = 1;
            if (c >= 2) begin
                chk("sat_we", 64'(wb_we), 64'd1);
                chk("sat_alternate", 64'(wb_addr >= 5'd16), 64'(c % 2));
            end
            @(posedge clk); #1;
            if (acc0) a0n = (a0n == 15) ? 1 : a0n + 1;
            if (acc1) a1n = (a1n == 31) ? 16 : a1n + 1;
        end
        idle_inputs();
        chk("sat_ready0_dropped", 64'(saw_nr0), 64'd1);
        chk("sat_ready1_dropped", 64'(saw_nr1), 64'd1);
        repeat (6) @(posedge clk);

        // Reset while both queues are loaded and the output stage is busy.
        #1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            req0_valid = 1'b1; req0_addr = AW'(1 + (c % 15)); req0_data = $urandom;
            req1_valid = 1'b1; req1_addr = AW'(16 + (c % 16)); req1_data = $urandom;
            @(negedge clk);
            if (wb_we && (mq0.size() + mq1.size()) >= DEPTH + 1) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("busy_before_reset", 64'(got), 64'd1);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("midop_we", 64'(wb_we), 64'd0);
        chk("midop_pending", 64'(pending), 64'd0);
        chk("midop_idle", 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midop_no_stale_we", 64'(wb_we), 64'd0);
        end

        // Randomized traffic; req0 and req1 use disjoint register ranges.
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 15));
            req0_data  = $urandom;
            req1_valid = ($urandom_range(0, 2) == 0);
            req1_addr  = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(16, 31));
            req1_data  = $urandom;
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", 64'(idle), 64'd1);
        chk("scoreboard_writes", 64'(dut_wr_cnt), 64'(m_acc_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
